// File: rtl/mult_err_acc.sv
// -----------------------------------------------------------------------------
// mult_err_acc
//
// Error-statistics collector that sits directly downstream of mult_top. It
// samples the operands fed to the approximate multiplier, forms the exact
// product internally, lines it up with the registered approximate product and
// accumulates error metrics over a run of N_SAMPLES valid samples.
//
// Parameters
//   N_SAMPLES  valid samples per run (1..65535)
//   ACC_W      width of the sum_abs_err / bias_sum accumulators (>= 33)
//   MULT_LAT   edges from x/y sampling to the matching p_approx (>= 1)
//
// Ports
//   clk          in   1      clock, all state on the rising edge
//   rst_n        in   1      asynchronous active-low reset
//   start        in   1      begin a run (honoured only in IDLE)
//   in_valid     in   1      x/y this cycle are a sample
//   x, y         in   16     multiplier operands (unsigned)
//   p_approx     in   32     approximate product from mult_top
//   busy         out  1      high in RUN and DRAIN
//   done         out  1      one-cycle pulse, results final
//   sum_abs_err  out  ACC_W  saturating sum of |p_approx - x*y|
//   max_abs_err  out  32     largest |error| in the run
//   err_count    out  16     samples with non-zero error
//   sample_cnt   out  16     samples accepted in the current/last run
//   acc_sat      out  1      sticky, sum_abs_err saturated this run
//   bias_sum     out  ACC_W  signed sum of (p_approx - x*y)
//
// Optional feature: define MERR_BIAS_EN to build the signed bias accumulator.
// Without it bias_sum is tied to zero and no bias logic is built.
// -----------------------------------------------------------------------------
module mult_err_acc #(
  parameter int unsigned N_SAMPLES = 1024,
  parameter int unsigned ACC_W     = 48,
  parameter int unsigned MULT_LAT  = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  input  logic [15:0]      x,
  input  logic [15:0]      y,
  input  logic [31:0]      p_approx,
  output logic             busy,
  output logic             done,
  output logic [ACC_W-1:0] sum_abs_err,
  output logic [31:0]      max_abs_err,
  output logic [15:0]      err_count,
  output logic [15:0]      sample_cnt,
  output logic             acc_sat,
  output logic [ACC_W-1:0] bias_sum
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [15:0] LAST_IDX = 16'(N_SAMPLES - 1);

  logic [1:0]          state;
  logic                accept;
  logic                last_accept;
  logic                run_clear;
  logic [31:0]         prod;
  logic [31:0]         exact_pipe [MULT_LAT];
  logic [MULT_LAT-1:0] vld_pipe;
  logic [32:0]         diff;
  logic [31:0]         abs_diff;
  logic                err_vld;
  logic [31:0]         err_r;
  logic [ACC_W:0]      err_ext;
  logic [ACC_W:0]      sum_next;

  assign accept      = (state == ST_RUN) && in_valid;
  assign last_accept = accept && (sample_cnt == LAST_IDX);
  assign run_clear   = (state == ST_IDLE) && start;
  assign prod        = {16'd0, x} * {16'd0, y};

  assign busy = (state == ST_RUN) || (state == ST_DRAIN);
  assign done = (state == ST_DONE);

  // Run control. DRAIN waits until no sample is left anywhere in the
  // exact-product pipeline or the error register, so the last update has
  // landed before DONE is entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      sample_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state      <= ST_RUN;
            sample_cnt <= '0;
          end
        end
        ST_RUN: begin
          if (accept) begin
            sample_cnt <= sample_cnt + 16'd1;
          end
          if (last_accept) begin
            state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if ((vld_pipe == '0) && !err_vld) begin
            state <= ST_DONE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Exact product delay line. Stage 0 is loaded on the accepting edge, so
  // the last stage holds the product in the cycle before mult_top's
  // registered output for the same operands is sampled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      for (int i = 0; i < int'(MULT_LAT); i++) begin
        exact_pipe[i] <= '0;
      end
    end else begin
      vld_pipe[0]   <= accept;
      exact_pipe[0] <= prod;
      for (int i = 1; i < int'(MULT_LAT); i++) begin
        vld_pipe[i]   <= vld_pipe[i-1];
        exact_pipe[i] <= exact_pipe[i-1];
      end
    end
  end

  // 33-bit difference so the sign survives a full 32-bit range on both sides;
  // the magnitude always fits back into 32 bits.
  assign diff     = {1'b0, p_approx} - {1'b0, exact_pipe[MULT_LAT-1]};
  assign abs_diff = diff[32] ? (~diff[31:0] + 32'd1) : diff[31:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_vld <= 1'b0;
      err_r   <= '0;
    end else begin
      err_vld <= vld_pipe[MULT_LAT-1];
      if (vld_pipe[MULT_LAT-1]) begin
        err_r <= abs_diff;
      end
    end
  end

  // One spare carry bit detects overflow of the absolute-error sum.
  assign err_ext  = {{(ACC_W + 1 - 32){1'b0}}, err_r};
  assign sum_next = {1'b0, sum_abs_err} + err_ext;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_abs_err <= '0;
      max_abs_err <= '0;
      err_count   <= '0;
      acc_sat     <= 1'b0;
    end else if (run_clear) begin
      sum_abs_err <= '0;
      max_abs_err <= '0;
      err_count   <= '0;
      acc_sat     <= 1'b0;
    end else if (err_vld) begin
      if (sum_next[ACC_W]) begin
        sum_abs_err <= '1;
        acc_sat     <= 1'b1;
      end else begin
        sum_abs_err <= sum_next[ACC_W-1:0];
      end
      if (err_r > max_abs_err) begin
        max_abs_err <= err_r;
      end
      if ((err_r != 32'd0) && (err_count != 16'hFFFF)) begin
        err_count <= err_count + 16'd1;
      end
    end
  end

`ifdef MERR_BIAS_EN
  logic [32:0]      diff_r;
  logic [ACC_W-1:0] diff_sext;
  logic [ACC_W-1:0] bias_acc;

  assign diff_sext = {{(ACC_W - 32){diff_r[32]}}, diff_r[31:0]};
  assign bias_sum  = bias_acc;

  // Signed bias accumulator, plain two's-complement wrap with no saturation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      diff_r   <= '0;
      bias_acc <= '0;
    end else begin
      if (vld_pipe[MULT_LAT-1]) begin
        diff_r <= diff;
      end
      if (run_clear) begin
        bias_acc <= '0;
      end else if (err_vld) begin
        bias_acc <= bias_acc + diff_sext;
      end
    end
  end
`else
  assign bias_sum = '0;
`endif

endmodule

// File: tb/tb_mult_err_acc.sv
// -----------------------------------------------------------------------------
// tb_mult_err_acc
//
// Directed bench for mult_err_acc. Two instances share the operand bus: the
// main one (N_SAMPLES=4, ACC_W=48) and a narrow one (N_SAMPLES=3, ACC_W=33)
// used for accumulator saturation. p_approx is replayed two cycles after its
// operands, mimicking mult_top's two-edge latency.
// -----------------------------------------------------------------------------
module tb_mult_err_acc;

`ifdef MERR_BIAS_EN
  localparam bit BIAS_ON = 1'b1;
`else
  localparam bit BIAS_ON = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        start_sat;
  logic        in_valid;
  logic [15:0] x;
  logic [15:0] y;
  logic [31:0] p_approx;

  logic        busy,        s_busy;
  logic        done,        s_done;
  logic [47:0] sum_abs_err, bias_sum;
  logic [32:0] s_sum_abs_err, s_bias_sum;
  logic [31:0] max_abs_err, s_max_abs_err;
  logic [15:0] err_count,   s_err_count;
  logic [15:0] sample_cnt,  s_sample_cnt;
  logic        acc_sat,     s_acc_sat;

  logic [31:0] p_hist [2];
  int          n_cmp;
  int          n_bad;

  mult_err_acc #(.N_SAMPLES(4), .ACC_W(48), .MULT_LAT(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
    .x(x), .y(y), .p_approx(p_approx),
    .busy(busy), .done(done), .sum_abs_err(sum_abs_err),
    .max_abs_err(max_abs_err), .err_count(err_count),
    .sample_cnt(sample_cnt), .acc_sat(acc_sat), .bias_sum(bias_sum)
  );

  mult_err_acc #(.N_SAMPLES(3), .ACC_W(33), .MULT_LAT(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .start(start_sat), .in_valid(in_valid),
    .x(x), .y(y), .p_approx(p_approx),
    .busy(s_busy), .done(s_done), .sum_abs_err(s_sum_abs_err),
    .max_abs_err(s_max_abs_err), .err_count(s_err_count),
    .sample_cnt(s_sample_cnt), .acc_sat(s_acc_sat), .bias_sum(s_bias_sum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock of stimulus: operands now, the product supplied two calls
  // earlier on p_approx. Returns 1 time unit after the rising edge.
  task automatic applyStimulus(input logic v, input logic [15:0] xi,
                               input logic [15:0] yi, input logic [31:0] pi);
    in_valid  = v;
    x         = xi;
    y         = yi;
    p_approx  = p_hist[1];
    p_hist[1] = p_hist[0];
    p_hist[0] = pi;
    @(posedge clk);
    #1;
    start     = 1'b0;
    start_sat = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    n_cmp++;
    assert (observed === expected) else begin
      n_bad++;
      $error("[TB] FAIL %s: observed 'h%0h, expected 'h%0h", tag, observed, expected);
    end
  endtask

  task automatic waitDone(input bit use_sat, input int budget);
    int n;
    n = 0;
    while (((use_sat ? s_done : done) !== 1'b1) && (n < budget)) begin
      applyStimulus(1'b0, 16'd0, 16'd0, 32'd0);
      n++;
    end
    checkOutput(use_sat ? "sat_done_in_budget" : "done_in_budget",
                64'(use_sat ? s_done : done), 64'd1);
  endtask

  initial begin
    logic [15:0] xr, yr;
    logic [15:0] sq_vals [4];
    logic        t3_v [7];
    logic [15:0] t3_x [7];
    logic [15:0] t3_y [7];
    logic [31:0] t3_p [7];

    n_cmp     = 0;
    n_bad     = 0;
    rst_n     = 1'b0;
    start     = 1'b0;
    start_sat = 1'b0;
    in_valid  = 1'b0;
    x         = '0;
    y         = '0;
    p_approx  = '0;
    p_hist[0] = '0;
    p_hist[1] = '0;

    sq_vals = '{16'd3, 16'd10, 16'd100, 16'd255};
    t3_v = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    t3_x = '{16'd2, 16'd9, 16'd9, 16'd5, 16'd1000, 16'd9, 16'd7};
    t3_y = '{16'd3, 16'd9, 16'd9, 16'd5, 16'd1000, 16'd9, 16'd9};
    t3_p = '{32'd13, 32'd0, 32'd0, 32'd23, 32'd1000000, 32'd0, 32'd73};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_done", 64'(done), 64'd0);
    checkOutput("rst_sum", 64'(sum_abs_err), 64'd0);
    checkOutput("rst_max", 64'(max_abs_err), 64'd0);
    checkOutput("rst_errcnt", 64'(err_count), 64'd0);
    checkOutput("rst_cnt", 64'(sample_cnt), 64'd0);
    checkOutput("rst_sat", 64'(acc_sat), 64'd0);
    checkOutput("rst_bias", 64'(bias_sum), 64'd0);
    checkOutput("rst_s_sum", 64'(s_sum_abs_err), 64'd0);
    rst_n = 1'b1;
    applyStimulus(1'b0, 16'd0, 16'd0, 32'd0);

    // Test 1: exact products, done exactly four edges after the last sample
    $display("[TB] test 1: exact products");
    start = 1'b1;
    applyStimulus(1'b0, 16'd0, 16'd0, 32'd0);
    checkOutput("t1_busy_run", 64'(busy), 64'd1);
    for (int i = 0; i < 4; i++) begin
      xr = 16'($urandom);
      yr = 16'($urandom);
      applyStimulus(1'b1, xr, yr, {16'd0, xr} * {16'd0, yr});
    end
    checkOutput("t1_cnt", 64'(sample_cnt), 64'd4);
    checkOutput("t1_busy_drain", 64'(busy), 64'd1);
    for (int i = 1; i <= 3; i++) begin
      applyStimulus(1'b0, 16'd0, 16'd0, 32'd0);
      checkOutput("t1_done_early", 64'(done), 64'd0);
    end
    applyStimulus(1'b0, 16'd0, 16'd0, 32'd0);
    checkOutput("t1_done_k4", 64'(done), 64'd1);
    checkOutput("t1_busy_done", 64'(busy), 64'd0);
    checkOutput("t1_sum", 64'(sum_abs_err), 64'd0);
    checkOutput("t1_max", 64'(max_abs_err), 64'd0);
    checkOutput("t1_errcnt", 64'(err_count), 64'd0);
    checkOutput("t1_bias", 64'(bias_sum), 64'd0);
    applyStimulus(1'b0, 16'd0, 16'd0, 32'd0);
    checkOutput("t1_done_pulse", 64'(done), 64'd0);

    // Test 2: constant +5 error
    $display("[TB] test 2: constant +5 error");
    start = 1'b1;
    applyStimulus(1'b0, 16'd0, 16'd0, 32'd0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, sq_vals[i], sq_vals[i],
                    {16'd0, sq_vals[i]} * {16'd0, sq_vals[i]} + 32'd5);
    end
    waitDone(1'b0, 10);
    checkOutput("t2_sum", 64'(sum_abs_err), 64'd20);
    checkOutput("t2_max", 64'(max_abs_err), 64'd5);
    checkOutput("t2_errcnt", 64'(err_count), 64'd4);
    checkOutput("t2_cnt", 64'(sample_cnt), 64'd4);
    checkOutput("t2_bias", 64'(bias_sum), BIAS_ON ? 64'd20 : 64'd0);
    applyStimulus(1'b0, 16'd0, 16'd0, 32'd0);
    checkOutput("t2_done_drop", 64'(done), 64'd0);

    // Test 3: gapped in_valid, mixed-sign errors, in_valid during DRAIN
    $display("[TB] test 3: gapped valid");
    start = 1'b1;
    applyStimulus(1'b0, 16'd0, 16'd0, 32'd0);
    for (int i = 0; i < 7; i++) begin
      applyStimulus(t3_v[i], t3_x[i], t3_y[i], t3_p[i]);
    end
    checkOutput("t3_cnt", 64'(sample_cnt), 64'd4);
    applyStimulus(1'b1, 16'd9, 16'd9, 32'd0);
    applyStimulus(1'b1, 16'd9, 16'd9, 32'd0);
    checkOutput("t3_cnt_drain", 64'(sample_cnt), 64'd4);
    waitDone(1'b0, 10);
    checkOutput("t3_sum", 64'(sum_abs_err), 64'd19);
    checkOutput("t3_max", 64'(max_abs_err), 64'd10);
    checkOutput("t3_errcnt", 64'(err_count), 64'd3);
    checkOutput("t3_bias", 64'(bias_sum), BIAS_ON ? 64'd15 : 64'd0);
    applyStimulus(1'b0, 16'd0, 16'd0, 32'd0);
    checkOutput("t3_done_drop", 64'(done), 64'd0);
    checkOutput("t3_busy_low", 64'(busy), 64'd0);
    applyStimulus(1'b0, 16'd0, 16'd0, 32'd0);
    checkOutput("t3_no_2nd_done", 64'(done), 64'd0);

    // Test 4: in_valid in IDLE, start+in_valid in IDLE, start during RUN
    $display("[TB] test 4: ignored start/valid");
    applyStimulus(1'b1, 16'd9, 16'd9, 32'd0);
    applyStimulus(1'b1, 16'd9, 16'd9, 32'd0);
    checkOutput("t4_idle_cnt", 64'(sample_cnt), 64'd4);
    checkOutput("t4_idle_sum", 64'(sum_abs_err), 64'd19);
    checkOutput("t4_idle_busy", 64'(busy), 64'd0);
    start = 1'b1;
    applyStimulus(1'b1, 16'd4, 16'd4, 32'd19);
    checkOutput("t4_start_cnt", 64'(sample_cnt), 64'd0);
    checkOutput("t4_start_clr", 64'(sum_abs_err), 64'd0);
    applyStimulus(1'b1, 16'd4, 16'd4, 32'd19);
    applyStimulus(1'b1, 16'd4, 16'd4, 32'd19);
    start = 1'b1;
    applyStimulus(1'b1, 16'd4, 16'd4, 32'd19);
    checkOutput("t4_run_start_cnt", 64'(sample_cnt), 64'd3);
    applyStimulus(1'b1, 16'd4, 16'd4, 32'd19);
    waitDone(1'b0, 10);
    checkOutput("t4_cnt", 64'(sample_cnt), 64'd4);
    checkOutput("t4_sum", 64'(sum_abs_err), 64'd12);
    checkOutput("t4_max", 64'(max_abs_err), 64'd3);
    checkOutput("t4_errcnt", 64'(err_count), 64'd4);
    applyStimulus(1'b0, 16'd0, 16'd0, 32'd0);

    // Test 5: reset mid-run, then a clean run
    $display("[TB] test 5: reset mid-run");
    start = 1'b1;
    applyStimulus(1'b0, 16'd0, 16'd0, 32'd0);
    applyStimulus(1'b1, 16'd2, 16'd2, 32'd12);
    applyStimulus(1'b1, 16'd2, 16'd2, 32'd12);
    applyStimulus(1'b0, 16'd0, 16'd0, 32'd0);
    applyStimulus(1'b0, 16'd0, 16'd0, 32'd0);
    checkOutput("t5_partial_sum", 64'(sum_abs_err), 64'd8);
    rst_n = 1'b0;
    #2;
    checkOutput("t5_rst_busy", 64'(busy), 64'd0);
    checkOutput("t5_rst_sum", 64'(sum_abs_err), 64'd0);
    checkOutput("t5_rst_max", 64'(max_abs_err), 64'd0);
    checkOutput("t5_rst_errcnt", 64'(err_count), 64'd0);
    checkOutput("t5_rst_cnt", 64'(sample_cnt), 64'd0);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b0, 16'd0, 16'd0, 32'd0);
      checkOutput("t5_rst_no_done", 64'(done), 64'd0);
    end
    rst_n = 1'b1;
    applyStimulus(1'b0, 16'd0, 16'd0, 32'd0);
    start = 1'b1;
    applyStimulus(1'b0, 16'd0, 16'd0, 32'd0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 16'd6, 16'd6, 32'd37);
    end
    waitDone(1'b0, 10);
    checkOutput("t5_sum", 64'(sum_abs_err), 64'd4);
    checkOutput("t5_max", 64'(max_abs_err), 64'd1);
    checkOutput("t5_errcnt", 64'(err_count), 64'd4);
    checkOutput("t5_cnt", 64'(sample_cnt), 64'd4);
    checkOutput("t5_bias", 64'(bias_sum), BIAS_ON ? 64'd4 : 64'd0);
    applyStimulus(1'b0, 16'd0, 16'd0, 32'd0);

    // Test 6: saturation on the 33-bit instance, then bias of -9
    $display("[TB] test 6: saturation");
    start_sat = 1'b1;
    applyStimulus(1'b0, 16'd0, 16'd0, 32'd0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 16'd0, 16'd0, 32'hFFFF_FFFF);
    end
    waitDone(1'b1, 10);
    checkOutput("t6_sum_sat", 64'(s_sum_abs_err), 64'h1_FFFF_FFFF);
    checkOutput("t6_acc_sat", 64'(s_acc_sat), 64'd1);
    checkOutput("t6_max", 64'(s_max_abs_err), 64'hFFFF_FFFF);
    checkOutput("t6_errcnt", 64'(s_err_count), 64'd3);
    checkOutput("t6_cnt", 64'(s_sample_cnt), 64'd3);
    checkOutput("t6_main_cnt", 64'(sample_cnt), 64'd4);
    checkOutput("t6_main_sum", 64'(sum_abs_err), 64'd4);
    applyStimulus(1'b0, 16'd0, 16'd0, 32'd0);
    start_sat = 1'b1;
    applyStimulus(1'b0, 16'd0, 16'd0, 32'd0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 16'd10, 16'd10, 32'd97);
    end
    waitDone(1'b1, 10);
    checkOutput("t6_sat_cleared", 64'(s_acc_sat), 64'd0);
    checkOutput("t6_sum2", 64'(s_sum_abs_err), 64'd9);
    checkOutput("t6_max2", 64'(s_max_abs_err), 64'd3);
    checkOutput("t6_bias", 64'(s_bias_sum), BIAS_ON ? 64'h1_FFFF_FFF7 : 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
